cpu_core: RTL and testbench

- 32-bit MIPS32-subset integer core with a classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
- Instruction memory is external and combinational: the core drives pc_out, and the instruction for that address is presented on instruction in the same cycle.
- There is a single data-memory port, with a stall input.
- The core sits between the board-level clock/reset and the memory/bus controller.

---
 rtl/cpu_core_pkg.sv | 83 ++++++++
 rtl/cpu_core_regfile.sv | 34 +++
 rtl/cpu_core.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// rtl/cpu_core_pkg.sv - shared constants, ALU op enum and pipeline payload structs for cpu_core
package cpu_core_pkg;
    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_MOVZ = 6'h0a;
    localparam logic [5:0] F_MOVN = 6'h0b;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    // mem_ctrl: [0]=read, [1]=write, [3:2]=size (00 word), [4]=sign-extend
    localparam int         MC_READ       = 0;
    localparam int         MC_WRITE      = 1;
    localparam logic [4:0] MEM_CTRL_IDLE = 5'b00000;
    localparam logic [4:0] MEM_CTRL_LW   = 5'b00001;
    localparam logic [4:0] MEM_CTRL_SW   = 5'b00010;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_LUI, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_MOVN, ALU_MOVZ, ALU_MFHI, ALU_MFLO, ALU_ADD
    } alu_op_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
    } if_id_t;

    typedef struct packed {
        alu_op_e               alu_op;
        logic [4:0]            rs_addr;
        logic [4:0]            rt_addr;
        logic [DATA_WIDTH-1:0] rs_val;
        logic [DATA_WIDTH-1:0] rt_val;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            shamt;
        logic                  use_imm;
        logic                  shift_var;
        logic [4:0]            waddr;
        logic                  hi_we;
        logic                  lo_we;
        logic [4:0]            mem_ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_res;
        logic [DATA_WIDTH-1:0] store_data;
        logic [4:0]            waddr;
        logic                  hi_we;
        logic                  lo_we;
        logic [4:0]            mem_ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] wdata;
        logic [4:0]            waddr;
        logic                  hi_we;
        logic                  lo_we;
    } mem_wb_t;

    function automatic logic [DATA_WIDTH-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/cpu_core_regfile.sv
// rtl/cpu_core_regfile.sv - 32x32 GPR file, two read ports, one write port, write-first
module cpu_core_regfile
    import cpu_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [4:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic [4:0]            i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);
    logic [DATA_WIDTH-1:0] r_regs [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != 5'd0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Same-cycle WB data bypasses the array so ID never sees a stale value
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if (i_we && i_waddr == i_raddr_a) o_rdata_a = i_wdata;
        if (i_we && i_waddr == i_raddr_b) o_rdata_b = i_wdata;
        if (i_raddr_a == 5'd0) o_rdata_a = '0;
        if (i_raddr_b == 5'd0) o_rdata_b = '0;
    end
endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 5-stage in-order MIPS32-subset core (logic, shift, move, LW/SW)
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk_50M,
    input  logic                  reset_btn,
    input  logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [4:0]            mem_ctrl_signal,
    input  logic                  mem_stall
);
    logic [ADDR_WIDTH-1:0] r_pc;
    if_id_t                r_if_id;
    id_ex_t                r_id_ex, w_dec;
    ex_mem_t               r_ex_mem, w_ex;
    mem_wb_t               r_mem_wb, w_wb;
    logic [DATA_WIDTH-1:0] r_hi, r_lo;

    logic [5:0]            w_op, w_funct;
    logic [4:0]            w_rs_addr, w_rt_addr, w_rd_addr, w_shamt;
    logic [15:0]           w_imm16;
    logic [DATA_WIDTH-1:0] w_rf_a, w_rf_b, w_rs, w_rt, w_hi, w_lo, w_b;
    logic [4:0]            w_sh;
    logic                  w_use_rs, w_use_rt, w_load_use, w_rf_we;
    logic [4:0]            wb_reg_waddr;
    logic [DATA_WIDTH-1:0] wb_reg_wdata;

    assign {w_op, w_rs_addr, w_rt_addr, w_rd_addr, w_shamt, w_funct} = r_if_id.inst;
    assign w_imm16 = r_if_id.inst[15:0];

    assign wb_reg_waddr = r_mem_wb.waddr;
    assign wb_reg_wdata = r_mem_wb.wdata;
    assign w_rf_we      = !mem_stall && (r_mem_wb.waddr != 5'd0);

    cpu_core_regfile u_regfile (
        .clk       (clk_50M),
        .rst_n     (reset_btn),
        .i_we      (w_rf_we),
        .i_waddr   (r_mem_wb.waddr),
        .i_wdata   (r_mem_wb.wdata),
        .i_raddr_a (w_rs_addr),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (w_rt_addr),
        .o_rdata_b (w_rf_b)
    );

    // Unsupported encodings fall through with waddr=0 and mem_ctrl=0, i.e. a NOP
    always_comb begin
        w_dec         = '0;
        w_dec.rs_addr = w_rs_addr;
        w_dec.rt_addr = w_rt_addr;
        w_dec.rs_val  = w_rf_a;
        w_dec.rt_val  = w_rf_b;
        w_dec.imm     = {16'h0000, w_imm16};
        w_dec.shamt   = w_shamt;
        w_use_rs      = 1'b0;
        w_use_rt      = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                w_use_rs    = 1'b1;
                w_use_rt    = 1'b1;
                w_dec.waddr = w_rd_addr;
                case (w_funct)
                    F_SLL:  begin w_dec.alu_op = ALU_SLL; w_use_rs = 1'b0; end
                    F_SRL:  begin w_dec.alu_op = ALU_SRL; w_use_rs = 1'b0; end
                    F_SRA:  begin w_dec.alu_op = ALU_SRA; w_use_rs = 1'b0; end
                    F_SLLV: begin w_dec.alu_op = ALU_SLL; w_dec.shift_var = 1'b1; end
                    F_SRLV: begin w_dec.alu_op = ALU_SRL; w_dec.shift_var = 1'b1; end
                    F_SRAV: begin w_dec.alu_op = ALU_SRA; w_dec.shift_var = 1'b1; end
                    F_MOVZ: w_dec.alu_op = ALU_MOVZ;
                    F_MOVN: w_dec.alu_op = ALU_MOVN;
                    F_MFHI: begin w_dec.alu_op = ALU_MFHI; w_use_rs = 1'b0; w_use_rt = 1'b0; end
                    F_MFLO: begin w_dec.alu_op = ALU_MFLO; w_use_rs = 1'b0; w_use_rt = 1'b0; end
                    F_MTHI, F_MTLO: begin
                        w_dec.alu_op  = ALU_OR;
                        w_dec.use_imm = 1'b1;
                        w_dec.imm     = '0;
                        w_dec.waddr   = 5'd0;
                        w_dec.hi_we   = (w_funct == F_MTHI);
                        w_dec.lo_we   = (w_funct == F_MTLO);
                        w_use_rt      = 1'b0;
                    end
                    F_AND:  w_dec.alu_op = ALU_AND;
                    F_OR:   w_dec.alu_op = ALU_OR;
                    F_XOR:  w_dec.alu_op = ALU_XOR;
                    F_NOR:  w_dec.alu_op = ALU_NOR;
                    default: begin w_dec.waddr = 5'd0; w_use_rs = 1'b0; w_use_rt = 1'b0; end
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_dec.alu_op  = (w_op == OP_ANDI) ? ALU_AND : (w_op == OP_ORI) ? ALU_OR : ALU_XOR;
                w_dec.use_imm = 1'b1;
                w_dec.waddr   = w_rt_addr;
                w_use_rs      = 1'b1;
            end
            OP_LUI: begin
                w_dec.alu_op = ALU_LUI;
                w_dec.waddr  = w_rt_addr;
            end
            OP_LW, OP_SW: begin
                w_dec.alu_op   = ALU_ADD;
                w_dec.imm      = sign_ext16(w_imm16);
                w_dec.waddr    = (w_op == OP_LW) ? w_rt_addr : 5'd0;
                w_dec.mem_ctrl = (w_op == OP_LW) ? MEM_CTRL_LW : MEM_CTRL_SW;
                w_use_rs       = 1'b1;
                w_use_rt       = (w_op == OP_SW);
            end
            default: ;
        endcase
    end

    assign w_load_use = r_id_ex.mem_ctrl[MC_READ] && (r_id_ex.waddr != 5'd0) &&
                        ((w_use_rs && w_rs_addr == r_id_ex.waddr) ||
                         (w_use_rt && w_rt_addr == r_id_ex.waddr));

    // EX/MEM is checked first so the younger producer wins
    always_comb begin
        w_rs = r_id_ex.rs_val;
        w_rt = r_id_ex.rt_val;
        w_hi = r_hi;
        w_lo = r_lo;
        if (r_ex_mem.waddr != 5'd0 && r_ex_mem.waddr == r_id_ex.rs_addr) w_rs = r_ex_mem.alu_res;
        else if (r_mem_wb.waddr != 5'd0 && r_mem_wb.waddr == r_id_ex.rs_addr) w_rs = r_mem_wb.wdata;
        if (r_ex_mem.waddr != 5'd0 && r_ex_mem.waddr == r_id_ex.rt_addr) w_rt = r_ex_mem.alu_res;
        else if (r_mem_wb.waddr != 5'd0 && r_mem_wb.waddr == r_id_ex.rt_addr) w_rt = r_mem_wb.wdata;
        if (r_ex_mem.hi_we) w_hi = r_ex_mem.alu_res;
        else if (r_mem_wb.hi_we) w_hi = r_mem_wb.wdata;
        if (r_ex_mem.lo_we) w_lo = r_ex_mem.alu_res;
        else if (r_mem_wb.lo_we) w_lo = r_mem_wb.wdata;
    end

    assign w_b  = r_id_ex.use_imm ? r_id_ex.imm : w_rt;
    assign w_sh = r_id_ex.shift_var ? w_rs[4:0] : r_id_ex.shamt;

    always_comb begin
        w_ex            = '0;
        w_ex.store_data = w_rt;
        w_ex.waddr      = r_id_ex.waddr;
        w_ex.hi_we      = r_id_ex.hi_we;
        w_ex.lo_we      = r_id_ex.lo_we;
        w_ex.mem_ctrl   = r_id_ex.mem_ctrl;
        case (r_id_ex.alu_op)
            ALU_AND:  w_ex.alu_res = w_rs & w_b;
            ALU_OR:   w_ex.alu_res = w_rs | w_b;
            ALU_XOR:  w_ex.alu_res = w_rs ^ w_b;
            ALU_NOR:  w_ex.alu_res = ~(w_rs | w_b);
            ALU_LUI:  w_ex.alu_res = {r_id_ex.imm[15:0], 16'h0000};
            ALU_SLL:  w_ex.alu_res = w_rt << w_sh;
            ALU_SRL:  w_ex.alu_res = w_rt >> w_sh;
            ALU_SRA:  w_ex.alu_res = 32'($signed(w_rt) >>> w_sh);
            ALU_MOVN: begin w_ex.alu_res = w_rs; if (w_rt == '0) w_ex.waddr = 5'd0; end
            ALU_MOVZ: begin w_ex.alu_res = w_rs; if (w_rt != '0) w_ex.waddr = 5'd0; end
            ALU_MFHI: w_ex.alu_res = w_hi;
            ALU_MFLO: w_ex.alu_res = w_lo;
            ALU_ADD:  w_ex.alu_res = w_rs + r_id_ex.imm;
            default:  ;
        endcase
    end

    always_comb begin
        w_wb       = '0;
        w_wb.waddr = r_ex_mem.waddr;
        w_wb.hi_we = r_ex_mem.hi_we;
        w_wb.lo_we = r_ex_mem.lo_we;
        w_wb.wdata = r_ex_mem.mem_ctrl[MC_READ] ? mem_rdata : r_ex_mem.alu_res;
    end

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_pc     <= RESET_PC;
            r_if_id  <= '0;
            r_id_ex  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (!mem_stall) begin
            if (w_load_use) begin
                r_id_ex <= '0;
            end else begin
                r_pc          <= r_pc + 32'd4;
                r_if_id.inst  <= instruction;
                r_id_ex       <= w_dec;
            end
            r_ex_mem <= w_ex;
            r_mem_wb <= w_wb;
            if (r_mem_wb.hi_we) r_hi <= r_mem_wb.wdata;
            if (r_mem_wb.lo_we) r_lo <= r_mem_wb.wdata;
        end
    end

    assign pc_out          = r_pc;
    assign mem_addr        = r_ex_mem.alu_res;
    assign mem_wdata       = r_ex_mem.store_data;
    assign mem_ctrl_signal = r_ex_mem.mem_ctrl;
endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - scoreboard bench for cpu_core: writeback and memory traffic vs hand-computed program results
module tb_cpu_core;
    logic        clk_50M   = 1'b0;
    logic        reset_btn = 1'b1;
    logic        mem_stall = 1'b0;
    logic [31:0] instruction, pc_out, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  mem_ctrl_signal;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] imem   [0:63];
    logic [31:0] dmem   [0:15];
    logic [31:0] pc_tab [0:12];

    typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wb_exp_t;
    typedef struct { int cyc; logic [4:0] ctrl; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    wb_exp_t  wb_q  [$];
    mem_exp_t mem_q [$];
    wb_exp_t  e_wb;
    mem_exp_t e_mem;

    always #10 clk_50M = ~clk_50M;

    cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk_50M         (clk_50M),
        .reset_btn       (reset_btn),
        .instruction     (instruction),
        .pc_out          (pc_out),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ctrl_signal (mem_ctrl_signal),
        .mem_stall       (mem_stall)
    );

    assign instruction = imem[pc_out[7:2]];
    assign mem_rdata   = dmem[mem_addr[5:2]];

    always @(posedge clk_50M) begin
        if (reset_btn && !mem_stall && mem_ctrl_signal[1]) dmem[mem_addr[5:2]] <= mem_wdata;
        cyc <= reset_btn ? cyc + 1 : 0;
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input int c, input logic [4:0] a, input logic [31:0] d);
        wb_q.push_back('{c, a, d});
    endtask

    task automatic exp_mem(input int c, input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] d);
        mem_q.push_back('{c, ctl, a, d});
    endtask

    // Committed events only: a stalled cycle does not retire anything
    always @(negedge clk_50M) begin
        if (reset_btn && cyc <= 12) check($sformatf("pc_out@cyc%0d", cyc), pc_out, pc_tab[cyc]);
        if (reset_btn && !mem_stall) begin
            if (dut.wb_reg_waddr != 5'd0) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected_waddr", {27'd0, dut.wb_reg_waddr}, 32'd0);
                end else begin
                    e_wb = wb_q.pop_front();
                    check($sformatf("wb_cycle($%0d)", e_wb.addr), 32'(cyc), 32'(e_wb.cyc));
                    check($sformatf("wb_waddr@cyc%0d", cyc), {27'd0, dut.wb_reg_waddr}, {27'd0, e_wb.addr});
                    check($sformatf("wb_wdata@cyc%0d", cyc), dut.wb_reg_wdata, e_wb.data);
                end
            end
            if (mem_ctrl_signal != 5'd0) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_ctrl", {27'd0, mem_ctrl_signal}, 32'd0);
                end else begin
                    e_mem = mem_q.pop_front();
                    check("mem_cycle", 32'(cyc), 32'(e_mem.cyc));
                    check($sformatf("mem_ctrl@cyc%0d", cyc), {27'd0, mem_ctrl_signal}, {27'd0, e_mem.ctrl});
                    check($sformatf("mem_addr@cyc%0d", cyc), mem_addr, e_mem.addr);
                    if (e_mem.ctrl[1]) check($sformatf("mem_wdata@cyc%0d", cyc), mem_wdata, e_mem.wdata);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
        for (int i = 0; i < 16; i++) dmem[i] = 32'hdead_beef;
        for (int i = 0; i < 13; i++) pc_tab[i] = (i < 8) ? 32'(4 * i) : (i < 12) ? 32'd32 : 32'd36;

        // mem_stall spans cycles 8..10, so results due at cycle 8 or later retire 3 cycles later;
        // the load-use bubble after the lw adds one more cycle to everything that follows it.
        imem[0]  = i_ins(6'h0d, 5'd0, 5'd1, 16'h1100);     exp_wb(4,  5'd1,  32'h0000_1100);
        imem[1]  = i_ins(6'h0d, 5'd0, 5'd1, 16'hff00);     exp_wb(5,  5'd1,  32'h0000_ff00);
        imem[2]  = i_ins(6'h0d, 5'd1, 5'd2, 16'h00ff);     exp_wb(6,  5'd2,  32'h0000_ffff);
        imem[3]  = i_ins(6'h0f, 5'd0, 5'd2, 16'h0404);     exp_wb(7,  5'd2,  32'h0404_0000);
        imem[4]  = i_ins(6'h0d, 5'd2, 5'd2, 16'h0404);     exp_wb(11, 5'd2,  32'h0404_0404);
        imem[5]  = r_ins(5'd0, 5'd2, 5'd2, 5'd8, 6'h00);   exp_wb(12, 5'd2,  32'h0404_0400);
        imem[6]  = r_ins(5'd0, 5'd2, 5'd2, 5'd8, 6'h02);   exp_wb(13, 5'd2,  32'h0004_0404);
        imem[7]  = i_ins(6'h0f, 5'd0, 5'd3, 16'h8000);     exp_wb(14, 5'd3,  32'h8000_0000);
        imem[8]  = r_ins(5'd0, 5'd3, 5'd3, 5'd4, 6'h03);   exp_wb(15, 5'd3,  32'hf800_0000);
        imem[9]  = i_ins(6'h0d, 5'd0, 5'd5, 16'h0004);     exp_wb(16, 5'd5,  32'h0000_0004);
        imem[10] = r_ins(5'd5, 5'd3, 5'd3, 5'd0, 6'h07);   exp_wb(17, 5'd3,  32'hff80_0000);
        imem[11] = i_ins(6'h0d, 5'd0, 5'd1, 16'h1234);     exp_wb(18, 5'd1,  32'h0000_1234);
        imem[12] = r_ins(5'd1, 5'd0, 5'd0, 5'd0, 6'h11);
        imem[13] = r_ins(5'd0, 5'd0, 5'd4, 5'd0, 6'h10);   exp_wb(20, 5'd4,  32'h0000_1234);
        imem[14] = r_ins(5'd1, 5'd0, 5'd6, 5'd0, 6'h0a);   exp_wb(21, 5'd6,  32'h0000_1234);
        imem[15] = r_ins(5'd1, 5'd0, 5'd7, 5'd0, 6'h0b);
        imem[16] = i_ins(6'h2b, 5'd0, 5'd1, 16'h0000);     exp_mem(22, 5'b00010, 32'h0, 32'h0000_1234);
        imem[17] = i_ins(6'h23, 5'd0, 5'd2, 16'h0000);     exp_mem(23, 5'b00001, 32'h0, 32'h0);
                                                            exp_wb(24, 5'd2,  32'h0000_1234);
        imem[18] = i_ins(6'h0d, 5'd2, 5'd3, 16'h0000);     exp_wb(26, 5'd3,  32'h0000_1234);
        imem[19] = r_ins(5'd1, 5'd0, 5'd8, 5'd0, 6'h27);   exp_wb(27, 5'd8,  32'hffff_edcb);
        imem[20] = r_ins(5'd8, 5'd1, 5'd9, 5'd0, 6'h26);   exp_wb(28, 5'd9,  32'hffff_ffff);
        imem[21] = r_ins(5'd9, 5'd1, 5'd10, 5'd0, 6'h24);  exp_wb(29, 5'd10, 32'h0000_1234);
        imem[22] = r_ins(5'd9, 5'd0, 5'd0, 5'd0, 6'h13);
        imem[23] = r_ins(5'd0, 5'd0, 5'd11, 5'd0, 6'h12);  exp_wb(31, 5'd11, 32'hffff_ffff);
        imem[24] = i_ins(6'h0e, 5'd1, 5'd12, 16'hffff);    exp_wb(32, 5'd12, 32'h0000_edcb);
        imem[25] = r_ins(5'd5, 5'd1, 5'd13, 5'd0, 6'h04);  exp_wb(33, 5'd13, 32'h0001_2340);
        imem[26] = i_ins(6'h04, 5'd1, 5'd1, 16'h0004);
        imem[27] = r_ins(5'd13, 5'd5, 5'd14, 5'd0, 6'h25); exp_wb(35, 5'd14, 32'h0001_2344);

        #3 reset_btn = 1'b0;
        @(negedge clk_50M);
        check("reset_pc_out", pc_out, 32'h0);
        check("reset_mem_ctrl", {27'd0, mem_ctrl_signal}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_wb_waddr", {27'd0, dut.wb_reg_waddr}, 32'h0);

        @(posedge clk_50M);
        #1 reset_btn = 1'b1;
        while (cyc != 8) begin @(posedge clk_50M); #1; end
        mem_stall = 1'b1;
        repeat (3) begin @(posedge clk_50M); #1; end
        mem_stall = 1'b0;
        while (cyc < 45) begin @(posedge clk_50M); #1; end

        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        #5 reset_btn = 1'b0;
        #1;
        check("async_reset_pc_out", pc_out, 32'h0);
        check("async_reset_mem_ctrl", {27'd0, mem_ctrl_signal}, 32'h0);
        check("async_reset_wb_waddr", {27'd0, dut.wb_reg_waddr}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
